// File: rtl/i2s_frame_source.sv
// i2s_frame_source: bit/word clock generator and stereo frame FIFO feeding the I2S serializer.
// Frames are written by the host through a valid/ready port and presented one at a time on
// DLeft/DRight, updated only on the frame boundary (the Bclk falling tick that wraps bit 31->0).
module i2s_frame_source #(
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [15:0]                   wr_left,
    input  logic [15:0]                   wr_right,
    output logic                          wr_ready,
    output logic [15:0]                   DLeft,
    output logic [15:0]                   DRight,
    output logic                          Bclk,
    output logic                          Wclk,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [DivW-1:0] DivMax  = DivW'(BCLK_DIV - 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

    // Registered state
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic            bclk_q, bclk_d;
    logic            wclk_q, wclk_d;
    logic [15:0]     dleft_q, dleft_d;
    logic [15:0]     dright_q, dright_d;
    logic            underrun_q, underrun_d;
    logic            primed_q, primed_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0] count_q, count_d;

    // Frame storage; contents need no reset because count_q gates every read
    logic [15:0] mem_l_q [FIFO_DEPTH];
    logic [15:0] mem_r_q [FIFO_DEPTH];

    logic div_tick;
    logic fall_tick;
    logic frame_tick;
    logic fifo_empty;
    logic push;
    logic pop;

    assign div_tick   = (div_cnt_q == DivMax);
    assign fall_tick  = div_tick & bclk_q;
    assign frame_tick = fall_tick & (bit_cnt_q == 5'd31);
    assign fifo_empty = (count_q == '0);
    // Ready comes from registered count only, so a write while full is refused even on a pop
    assign wr_ready   = (count_q != LvlFull);
    assign push       = wr_valid & wr_ready;
    // No bypass: an empty FIFO at the boundary mutes even if a write lands in the same cycle
    assign pop        = frame_tick & ~fifo_empty;

    // Next-state for clocks, frame output and FIFO bookkeeping
    always_comb begin
        div_cnt_d  = div_tick ? '0 : div_cnt_q + DivW'(1);
        bclk_d     = bclk_q ^ div_tick;
        bit_cnt_d  = fall_tick ? bit_cnt_q + 5'd1 : bit_cnt_q;
        // Word clock tracks the upper half of the bit count, so it only moves on a falling tick
        wclk_d     = bit_cnt_d[4];

        dleft_d    = dleft_q;
        dright_d   = dright_q;
        underrun_d = 1'b0;
        if (frame_tick) begin
            if (fifo_empty) begin
                dleft_d    = 16'h0000;
                dright_d   = 16'h0000;
                underrun_d = primed_q;
            end else begin
                dleft_d    = mem_l_q[rd_ptr_q];
                dright_d   = mem_r_q[rd_ptr_q];
            end
        end

        primed_d = primed_q | push;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LvlW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LvlW'(1);
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= 5'd0;
            bclk_q     <= 1'b0;
            wclk_q     <= 1'b0;
            dleft_q    <= 16'h0000;
            dright_q   <= 16'h0000;
            underrun_q <= 1'b0;
            primed_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            wclk_q     <= wclk_d;
            dleft_q    <= dleft_d;
            dright_q   <= dright_d;
            underrun_q <= underrun_d;
            primed_q   <= primed_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= wr_left;
            mem_r_q[wr_ptr_q] <= wr_right;
        end
    end

    assign DLeft    = dleft_q;
    assign DRight   = dright_q;
    assign Bclk     = bclk_q;
    assign Wclk     = wclk_q;
    assign underrun = underrun_q;
    assign level    = count_q;

endmodule

// File: tb/tb_i2s_frame_source.sv
// Testbench for i2s_frame_source: directed scenarios plus random traffic, every output checked
// each cycle against a frame-level model (clock phases from cycle arithmetic, FIFO as a queue).
module tb_i2s_frame_source;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 64 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_left = 16'h0;
    logic [15:0] wr_right = 16'h0;
    logic        wr_ready;
    logic [15:0] DLeft;
    logic [15:0] DRight;
    logic        Bclk;
    logic        Wclk;
    logic        underrun;
    logic [2:0]  level;

    i2s_frame_source #(
        .BCLK_DIV   (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_left  (wr_left),
        .wr_right (wr_right),
        .wr_ready (wr_ready),
        .DLeft    (DLeft),
        .DRight   (DRight),
        .Bclk     (Bclk),
        .Wclk     (Wclk),
        .underrun (underrun),
        .level    (level)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q[$];
    int          m_cyc = 0;       // non-reset edges since reset release
    bit          m_primed = 1'b0;
    logic [15:0] m_dl = 16'h0;
    logic [15:0] m_dr = 16'h0;
    bit          m_und = 1'b0;
    bit          m_acc = 1'b0;    // write accepted at the last edge
    int          n_total = 0;
    int          n_pass = 0;
    int          n_under = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, m_cyc, obs, exp);
    endtask

    // One clock: update the model at the edge, then compare all outputs 1 time unit later
    task automatic tick();
        bit          rdy;
        logic [31:0] f;
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) begin
            q.delete();
            m_cyc = 0;
            m_primed = 1'b0;
            m_dl = 16'h0;
            m_dr = 16'h0;
            m_und = 1'b0;
        end else begin
            rdy = (q.size() != DEPTH);
            m_und = 1'b0;
            if (((m_cyc + 1) % FRAME) == 0) begin
                if (q.size() > 0) begin
                    f = q.pop_front();
                    m_dl = f[31:16];
                    m_dr = f[15:0];
                end else begin
                    m_dl = 16'h0;
                    m_dr = 16'h0;
                    m_und = m_primed;
                end
            end
            if (wr_valid && rdy) begin
                q.push_back({wr_left, wr_right});
                m_primed = 1'b1;
                m_acc = 1'b1;
            end
            m_cyc++;
        end
        #1;
        if (m_und) n_under++;
        chk("bclk", 32'(Bclk), 32'((m_cyc / D) % 2));
        chk("wclk", 32'(Wclk), 32'(((m_cyc / (2 * D)) % 32) >= 16));
        chk("dleft", 32'(DLeft), 32'(m_dl));
        chk("dright", 32'(DRight), 32'(m_dr));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("level", 32'(level), 32'(q.size()));
        chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wr_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_to(input int c);
        wr_valid = 1'b0;
        while (m_cyc < c) tick();
    endtask

    // Offer one frame for exactly the current cycle
    task automatic write_once(input logic [15:0] l, input logic [15:0] r);
        wr_valid = 1'b1;
        wr_left  = l;
        wr_right = r;
        tick();
        wr_valid = 1'b0;
    endtask

    // Hold a frame until the model says it was accepted (bounded)
    task automatic write_hold(input logic [15:0] l, input logic [15:0] r);
        int n;
        wr_valid = 1'b1;
        wr_left  = l;
        wr_right = r;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 4 * FRAME);
        wr_valid = 1'b0;
        chk("write_hold_bound", 32'(m_acc), 32'd1);
    endtask

    initial begin
        // Reset and clocks, no writes
        do_reset(3);
        idle(2 * FRAME + 20);
        chk("no_underrun_unprimed", 32'(n_under), 32'd0);

        // Single frame at cycle 10
        do_reset(2);
        run_to(10);
        write_once(16'h1234, 16'hABCD);
        run_to(FRAME);
        chk("single_dleft", 32'(DLeft), 32'h1234);
        chk("single_dright", 32'(DRight), 32'hABCD);
        run_to(2 * FRAME + 10);
        chk("single_underrun_once", 32'(n_under), 32'd1);

        // Full FIFO: five frames back to back from cycle 0
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            write_hold(16'($urandom), 16'($urandom));
        end
        idle(6 * FRAME);

        // Simultaneous push/pop with one queued, then a rejected write while full
        do_reset(2);
        run_to(5);
        write_once(16'($urandom), 16'($urandom));
        run_to(FRAME - 1);
        write_once(16'($urandom), 16'($urandom));
        chk("pushpop_level", 32'(level), 32'd1);
        for (int i = 0; i < 3; i++) write_once(16'($urandom), 16'($urandom));
        run_to(2 * FRAME - 1);
        write_once(16'hDEAD, 16'hBEEF);
        chk("full_reject_level", 32'(level), 32'd3);
        idle(20);

        // Empty-boundary write while primed
        do_reset(2);
        run_to(10);
        write_once(16'($urandom), 16'($urandom));
        n_under = 0;
        run_to(2 * FRAME - 1);
        write_once(16'h5A5A, 16'hA5A5);
        chk("empty_bnd_underrun", 32'(underrun), 32'd1);
        chk("empty_bnd_level", 32'(level), 32'd1);
        run_to(3 * FRAME + 2);
        chk("empty_bnd_dleft", 32'(DLeft), 32'h5A5A);

        // Mid-frame reset at bit 20 of the second frame with two frames queued
        do_reset(2);
        for (int i = 0; i < 3; i++) write_once(16'($urandom), 16'($urandom));
        run_to(FRAME + 20 * 2 * D + 2);
        chk("midreset_level", 32'(level), 32'd2);
        do_reset(1);
        n_under = 0;
        idle(2 * FRAME + 20);
        chk("midreset_no_underrun", 32'(n_under), 32'd0);

        // Random traffic: heavy then sparse
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 999) < ((i < 1500) ? 30 : 2));
            wr_left  = 16'($urandom);
            wr_right = 16'($urandom);
            tick();
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
